// File: rtl/mult_8x8_seq_ctrl.sv
// mult_8x8_seq_ctrl: time-multiplexed 8x8 approximate multiplier controller.
// Drives one external combinational 4x4 approximate core over four phases
// (LL, LH, HL, HH), accumulates shifted partial products into a 17-bit
// accumulator and returns a saturated 16-bit product over valid/ready.
// Optional build macro: MULT_SEQ_OR_COMBINE_EN -- OR-combines the two cross
// terms (P1 and P2 products) instead of adding them.
module mult_8x8_seq_ctrl #(
  parameter logic [1:0] MODE_P0 = 2'd3,
  parameter logic [1:0] MODE_P1 = 2'd2,
  parameter logic [1:0] MODE_P2 = 2'd2,
  parameter logic [1:0] MODE_P3 = 2'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] R,
  output logic        out_ovf,
  output logic [3:0]  sub_a,
  output logic [3:0]  sub_b,
  output logic [1:0]  sub_mode,
  input  logic [7:0]  sub_r,
  output logic        busy
);

  localparam int unsigned OPW  = 8;
  localparam int unsigned NIBW = 4;
  localparam int unsigned PPW  = 8;
  localparam int unsigned ACCW = 17;
  localparam int unsigned RW   = 16;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P0   = 3'd1,
    S_P1   = 3'd2,
    S_P2   = 3'd3,
    S_P3   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t          state;
  logic [OPW-1:0]  a_q;
  logic [OPW-1:0]  b_q;
  logic [ACCW-1:0] acc;
  logic [ACCW-1:0] acc_nxt;
  logic [RW-1:0]   r_sat;
  logic            accept;
`ifdef MULT_SEQ_OR_COMBINE_EN
  logic [ACCW-1:0] acc_p0;
  logic [PPW-1:0]  p1_q;
`endif

  // Operand handshake: open in IDLE, and in DONE only once the result is taken.
  assign in_ready = (state == S_IDLE) || ((state == S_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // Next accumulator value for the current phase.
  always_comb begin
    acc_nxt = acc;
    case (state)
      S_P0: acc_nxt = ACCW'(sub_r);
      S_P1: acc_nxt = acc + (ACCW'(sub_r) << 4);
`ifdef MULT_SEQ_OR_COMBINE_EN
      S_P2: acc_nxt = acc_p0 + (ACCW'(p1_q | sub_r) << 4);
`else
      S_P2: acc_nxt = acc + (ACCW'(sub_r) << 4);
`endif
      S_P3: acc_nxt = acc + (ACCW'(sub_r) << 8);
      default: acc_nxt = acc;
    endcase
  end

  // Saturate to 16 bits when the approximate sum spills into bit 16.
  assign r_sat = acc_nxt[ACCW-1] ? {RW{1'b1}} : acc_nxt[RW-1:0];

  // Controller FSM with registered outputs and core operand/mode selection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      R         <= '0;
      out_ovf   <= 1'b0;
      busy      <= 1'b0;
      sub_a     <= '0;
      sub_b     <= '0;
      sub_mode  <= '0;
`ifdef MULT_SEQ_OR_COMBINE_EN
      acc_p0    <= '0;
      p1_q      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          // Result consumed: drop it and return to idle unless a new pair follows.
          if ((state == S_DONE) && out_ready) begin
            out_valid <= 1'b0;
            R         <= '0;
            out_ovf   <= 1'b0;
            state     <= S_IDLE;
          end
          // Accept a new pair: latch operands and present the LL nibbles.
          if (accept) begin
            a_q      <= A;
            b_q      <= B;
            acc      <= '0;
            busy     <= 1'b1;
            sub_a    <= A[NIBW-1:0];
            sub_b    <= B[NIBW-1:0];
            sub_mode <= MODE_P0;
            state    <= S_P0;
          end
        end
        S_P0: begin
          acc      <= acc_nxt;
`ifdef MULT_SEQ_OR_COMBINE_EN
          acc_p0   <= acc_nxt;
`endif
          sub_a    <= a_q[NIBW-1:0];
          sub_b    <= b_q[OPW-1:NIBW];
          sub_mode <= MODE_P1;
          state    <= S_P1;
        end
        S_P1: begin
          acc      <= acc_nxt;
`ifdef MULT_SEQ_OR_COMBINE_EN
          p1_q     <= sub_r;
`endif
          sub_a    <= a_q[OPW-1:NIBW];
          sub_b    <= b_q[NIBW-1:0];
          sub_mode <= MODE_P2;
          state    <= S_P2;
        end
        S_P2: begin
          acc      <= acc_nxt;
          sub_a    <= a_q[OPW-1:NIBW];
          sub_b    <= b_q[OPW-1:NIBW];
          sub_mode <= MODE_P3;
          state    <= S_P3;
        end
        S_P3: begin
          acc       <= acc_nxt;
          sub_a     <= '0;
          sub_b     <= '0;
          sub_mode  <= '0;
          busy      <= 1'b0;
          out_valid <= 1'b1;
          R         <= r_sat;
          out_ovf   <= acc_nxt[ACCW-1];
          state     <= S_DONE;
        end
        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b0;
          sub_a     <= '0;
          sub_b     <= '0;
          sub_mode  <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/mult_8x8_seq_ctrl.md
Name: mult_8x8_seq_ctrl

Overview:
- Sequential controller that computes one 8x8 approximate product on a single shared 4x4 approximate multiplier core.
- The core is external and combinational. Over four phases the controller drives it with the nibble pairs LL, LH, HL and HH and selects a per-phase approximation mode.
- It accumulates the shifted partial products and returns a 16-bit result through valid/ready handshakes.
- It is the area-reduced, time-multiplexed counterpart of the four-instance 8x8 combinational multipliers in Mult_8X8.

Parameters:
- MODE_P0, 2'd3, core mode for the A[3:0] x B[3:0] phase.
- MODE_P1, 2'd2, core mode for the A[3:0] x B[7:4] phase.
- MODE_P2, 2'd2, core mode for the A[7:4] x B[3:0] phase.
- MODE_P3, 2'd1, core mode for the A[7:4] x B[7:4] phase.
- Mode encoding: 0 = exact, 1 = R1, 2 = R2, 3 = N2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  controller can accept operands.
- A  in  8  multiplicand.
- B  in  8  multiplier.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- R  out  16  product, saturated.
- out_ovf  out  1  accumulation exceeded 16 bits; R saturated. Qualified by out_valid.
- sub_a  out  4  core operand A nibble.
- sub_b  out  4  core operand B nibble.
- sub_mode  out  2  core approximation mode.
- sub_r  in  8  core product; combinational in sub_a, sub_b and sub_mode.
- busy  out  1  high in P0..P3.

Behaviour:
- One clock domain. rst is asynchronous and active-high; it forces state IDLE.
- Reset values: in_ready=1, out_valid=0, R=0, out_ovf=0, busy=0, sub_a=0, sub_b=0, sub_mode=0. The operand registers and the 17-bit accumulator also reset to 0.
- States: IDLE, P0, P1, P2, P3, DONE.
- IDLE: in_ready=1. If in_valid is high, latch A and B, clear the accumulator and go to P0.
- P0..P3: one cycle each, in_ready=0, busy=1.
  - sub_a and sub_b come combinationally from the latched operands: P0 = (A[3:0], B[3:0]), P1 = (A[3:0], B[7:4]), P2 = (A[7:4], B[3:0]), P3 = (A[7:4], B[7:4]).
  - sub_mode = MODE_Pn for the current phase.
  - sub_r is sampled at the clock edge that ends the phase.
  - Accumulator update: P0 acc = sub_r; P1 acc += sub_r<<4; P2 acc += sub_r<<4; P3 acc += sub_r<<8.
  - P3 goes to DONE.
- DONE: out_valid=1.
  - R = 16'hFFFF when acc[16]=1, else acc[15:0].
  - out_ovf = acc[16].
  - R and out_ovf stay stable while out_ready=0.
  - in_ready = out_ready.
  - out_ready=1 and in_valid=1: complete the handshake, latch new operands and go to P0 (back-to-back, throughput one result per 5 cycles).
  - out_ready=1 and in_valid=0: go to IDLE.
- Outside P0..P3, sub_a, sub_b and sub_mode are driven to 0.
- R and out_ovf are valid only with out_valid; in IDLE they read 0.
- Latency: handshake in cycle N puts out_valid high in cycle N+5 (phases in N+1..N+4).
- Maximum approximate sum is 73695, which needs the 17-bit accumulator. Exact mode can never overflow.
- In P0..P3, A, B and in_valid changes are ignored.
- Asserting rst mid-operation aborts the current product; no result is produced.

Optional Feature:
- Macro: MULT_SEQ_OR_COMBINE_EN.
- Defined: in P2 the update is acc = acc_p0 + ((p1 | sub_r)<<4), where:
  - p1 is the 8-bit P1 product, held in its own register;
  - acc_p0 is the P0 value, held in its own register.
  - This emulates an OR-compressor for the cross terms.
- Undefined: the exact addition described in Behaviour; the extra registers are absent.

Test Plan:
- Exact core model, all MODE_Pn=0: A=8'hFF, B=8'hFF -> R=16'hFE01 with out_valid 5 cycles after the handshake, out_ovf=0, sub_mode=0 throughout.
- Default modes, bench core returns 8'hFF every phase -> acc=73695 -> R=16'hFFFF, out_ovf=1. Check sub_mode sequence 3,2,2,1 and sub_a/sub_b nibble sequence for A=8'hA5, B=8'h3C: (5,C), (5,3), (A,C), (A,3).
- Core returns 8'h01, 8'h11, 8'h01, 8'h00 across P0..P3 -> R=16'h0121 without the macro, 16'h0111 with MULT_SEQ_OR_COMBINE_EN.
- Backpressure: hold out_ready=0 for 7 cycles in DONE -> R and out_valid stable, in_ready=0. Then out_ready=1 with in_valid=1 -> next pair accepted the same cycle, busy next cycle.
- Reset mid-operation: assert rst during P2 -> immediately in_ready=1, busy=0, R=0. After release, a new product of 8'h12 x 8'h34 on the exact model gives 16'h03A8.
